// File: rtl/qpp_addr_gen.sv
// ---------------------------------------------------------------------------
// qpp_addr_gen
//
// Purpose:
//   Generates the LTE turbo-interleaver QPP read address
//   pi(i) = (f1*i + f2*i^2) mod K, one address per accepted step.
//   It has no multipliers. The address is built by incremental recursion:
//     pi(i+1) = (pi(i) + g(i)) mod K
//     g(i+1)  = (g(i) + 2*f2) mod K,   with g(0) = (f1 + f2) mod K
//   Each modular sum reduces with one conditional subtract, because both
//   operands are always < K.
//
// Ports:
//   clk         in   single clock, rising edge
//   reset       in   synchronous, active-high; overrides everything else
//   start       in   begins a block; honoured only in IDLE
//   block_size  in   0 = K_SMALL, 1 = K_LARGE; sampled on an accepted start
//   step        in   advances to the next address; honoured only in RUN
//   addr        out  current interleaved address pi(index)
//   addr_valid  out  addr is meaningful (high in RUN)
//   addr_last   out  index == K-1 while addr_valid
//   index       out  current linear index i
//   busy        out  high in RUN
// ---------------------------------------------------------------------------
module qpp_addr_gen #(
  parameter int W        = 13,
  parameter int K_SMALL  = 1056,
  parameter int F1_SMALL = 17,
  parameter int F2_SMALL = 66,
  parameter int K_LARGE  = 6144,
  parameter int F1_LARGE = 263,
  parameter int F2_LARGE = 480
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         block_size,
  input  logic         step,
  output logic [W-1:0] addr,
  output logic         addr_valid,
  output logic         addr_last,
  output logic [W-1:0] index,
  output logic         busy
);

  // Per-size constants, pre-reduced so every recursion operand is < K.
  localparam logic [W-1:0] K_S  = W'(K_SMALL);
  localparam logic [W-1:0] K_L  = W'(K_LARGE);
  localparam logic [W-1:0] G0_S = W'((F1_SMALL + F2_SMALL) % K_SMALL);
  localparam logic [W-1:0] G0_L = W'((F1_LARGE + F2_LARGE) % K_LARGE);
  localparam logic [W-1:0] D_S  = W'((2 * F2_SMALL) % K_SMALL);
  localparam logic [W-1:0] D_L  = W'((2 * F2_LARGE) % K_LARGE);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t       state_reg, state_next;
  logic [W-1:0] addr_reg,  addr_next;
  logic [W-1:0] index_reg, index_next;
  logic [W-1:0] g_reg,     g_next;
  logic         size_reg,  size_next;

  logic [W-1:0] k_cur;
  logic [W-1:0] d_cur;
  logic         last_int;

  // (a + b) mod m for a, b < m. The sum is formed one bit wider so that
  // 2*(m-1) cannot overflow before the single conditional subtract.
  function automatic logic [W-1:0] mod_add(input logic [W-1:0] a,
                                           input logic [W-1:0] b,
                                           input logic [W-1:0] m);
    logic [W:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, m}) begin
      s = s - {1'b0, m};
    end
    return s[W-1:0];
  endfunction

  // K and 2*f2 follow the size latched at start, so block_size is ignored
  // during RUN.
  assign k_cur    = size_reg ? K_L : K_S;
  assign d_cur    = size_reg ? D_L : D_S;
  assign last_int = (state_reg == RUN) && (index_reg == (k_cur - W'(1)));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      addr_reg  <= '0;
      index_reg <= '0;
      g_reg     <= '0;
      size_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      addr_reg  <= addr_next;
      index_reg <= index_next;
      g_reg     <= g_next;
      size_reg  <= size_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    addr_next  = addr_reg;
    index_next = index_reg;
    g_next     = g_reg;
    size_next  = size_reg;

    unique case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = RUN;
          size_next  = block_size;
          addr_next  = '0;
          index_next = '0;
          g_next     = block_size ? G0_L : G0_S;
        end
      end
      RUN: begin
        if (step) begin
          if (last_int) begin
            // The final step only leaves RUN. The recursion registers keep
            // their end-of-block values.
            state_next = IDLE;
          end else begin
            addr_next  = mod_add(addr_reg, g_reg, k_cur);
            g_next     = mod_add(g_reg, d_cur, k_cur);
            index_next = index_reg + W'(1);
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign addr       = addr_reg;
  assign index      = index_reg;
  assign addr_valid = (state_reg == RUN);
  assign busy       = (state_reg == RUN);
  assign addr_last  = last_int;

endmodule

// File: tb/tb_qpp_addr_gen.sv
// ---------------------------------------------------------------------------
// tb_qpp_addr_gen
//
// Self-checking bench for qpp_addr_gen. A reference model computes
// pi(i) = (f1*i + f2*i^2) mod K directly, and the bench compares it with the
// DUT output on every cycle of each block. Steps arrive at random with a
// configurable probability. Inputs change on the falling edge, and outputs are
// sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_qpp_addr_gen;

  localparam int W = 13;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         block_size;
  logic         step;
  logic [W-1:0] addr;
  logic         addr_valid;
  logic         addr_last;
  logic [W-1:0] index;
  logic         busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  qpp_addr_gen dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .block_size (block_size),
    .step       (step),
    .addr       (addr),
    .addr_valid (addr_valid),
    .addr_last  (addr_last),
    .index      (index),
    .busy       (busy)
  );

  task automatic check(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic longint pi_ref(input longint k, input longint f1,
                                    input longint f2, input longint i);
    return (f1 * i + f2 * i * i) % k;
  endfunction

  task automatic check_idle_reset(input string tag);
    check({tag, "_addr"},  addr,       0);
    check({tag, "_index"}, index,      0);
    check({tag, "_valid"}, addr_valid, 0);
    check({tag, "_last"},  addr_last,  0);
    check({tag, "_busy"},  busy,       0);
  endtask

  // Runs one block. prob is the percentage of cycles in which step is
  // asserted. abort_at >= 0 asserts reset when the model index reaches it.
  // pulse_at >= 0 pulses start with block_size=1 at that index. When wiggle
  // is set, block_size is driven at random during RUN.
  task automatic run_block(input string name, input bit size, input int prob,
                           input int abort_at, input int pulse_at,
                           input bit distinct, input bit wiggle);
    longint k, f1, f2;
    int     i, cyc, bound, dup;
    bit     stp, new_i;
    bit     seen [];
    k  = size ? 6144 : 1056;
    f1 = size ? 263  : 17;
    f2 = size ? 480  : 66;
    bound = int'(k) * 10 + 100;
    dup = 0;
    if (distinct) seen = new[k];

    start = 1'b1;
    block_size = size;
    @(negedge clk);
    start = 1'b0;
    block_size = ~size;
    i = 0;
    cyc = 0;
    new_i = 1'b1;
    forever begin
      check({name, "_valid"}, addr_valid, 1);
      check({name, "_busy"},  busy,       1);
      check({name, "_index"}, index,      i);
      check({name, "_addr"},  addr,       pi_ref(k, f1, f2, i));
      check({name, "_last"},  addr_last,  (i == k - 1) ? 1 : 0);
      if (distinct && new_i && addr < k) begin
        if (seen[addr]) dup++;
        seen[addr] = 1'b1;
      end
      if (i == abort_at) begin
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_idle_reset({name, "_abort"});
        $display("%s: aborted by reset at index %0d", name, i);
        return;
      end
      stp = ($urandom_range(0, 99) < prob);
      step = stp;
      if (i == pulse_at) begin
        start = 1'b1;
        block_size = 1'b1;
      end
      if (wiggle) block_size = 1'($urandom_range(0, 1));
      @(negedge clk);
      step = 1'b0;
      start = 1'b0;
      cyc++;
      if (cyc > bound) begin
        check({name, "_cycle_budget"}, cyc, bound);
        return;
      end
      if (stp) begin
        if (i == k - 1) break;
        i++;
        new_i = 1'b1;
      end else begin
        new_i = 1'b0;
      end
    end
    // Block is done: RUN has been left and the final values are held.
    check({name, "_end_valid"}, addr_valid, 0);
    check({name, "_end_busy"},  busy,       0);
    check({name, "_end_last"},  addr_last,  0);
    check({name, "_end_index"}, index,      k - 1);
    check({name, "_end_addr"},  addr,       size ? 217 : 49);
    if (distinct) check({name, "_duplicates"}, dup, 0);
    $display("%s: K=%0d finished in %0d cycles, final addr %0d",
             name, k, cyc, addr);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    block_size = 1'b0;
    step = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_idle_reset("reset");
    reset = 1'b0;

    // Steps while IDLE must not move anything.
    for (int n = 0; n < 5; n++) begin
      step = 1'b1;
      @(negedge clk);
      check_idle_reset("idle_step");
    end
    step = 1'b0;
    $display("idle_step: 5 steps while IDLE, outputs held at reset values");

    run_block("small_cont",   1'b0, 100, -1, -1, 1'b1, 1'b0);
    run_block("large_cont",   1'b1, 100, -1, -1, 1'b1, 1'b0);
    run_block("small_stall",  1'b0, 50,  -1, -1, 1'b0, 1'b1);
    run_block("small_pulse",  1'b0, 100, -1, 10, 1'b0, 1'b0);
    run_block("large_abort",  1'b1, 100, 500, -1, 1'b0, 1'b0);
    run_block("small_after",  1'b0, 100, -1, -1, 1'b0, 1'b0);
    run_block("large_stall",  1'b1, 70,  -1, -1, 1'b1, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
